// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit XNOR Fibonacci LFSR (x^8+x^6+x^5+x^4+1): self-syncs, locks, counts bit errors.
// Optional seven-segment display of err_count[7:0] is compiled in when LFSR_CHK_HEX_EN is defined.

`ifdef LFSR_CHK_HEX_EN
module DEC_7SEG (
    input  logic [3:0] hex_digit,
    output logic [6:0] segments
);
    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
    always_comb begin
        case (hex_digit)
            4'h0:    segments = 7'h40;
            4'h1:    segments = 7'h79;
            4'h2:    segments = 7'h24;
            4'h3:    segments = 7'h30;
            4'h4:    segments = 7'h19;
            4'h5:    segments = 7'h12;
            4'h6:    segments = 7'h02;
            4'h7:    segments = 7'h78;
            4'h8:    segments = 7'h00;
            4'h9:    segments = 7'h10;
            4'hA:    segments = 7'h08;
            4'hB:    segments = 7'h03;
            4'hC:    segments = 7'h46;
            4'hD:    segments = 7'h21;
            4'hE:    segments = 7'h06;
            4'hF:    segments = 7'h0E;
            default: segments = 7'h7F;
        endcase
    end
endmodule
`endif

module lfsr_checker #(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk50mhz,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_err,
    output logic             locked,
    output logic [1:0]       state,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       seq_word,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    localparam logic [7:0]       LOCK_C  = 8'(LOCK_COUNT);
    localparam logic [7:0]       LOSS_C  = 8'(LOSS_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Next bit the generator would emit from the current window (XNOR of taps 7,5,4,3)
    function automatic logic lfsr_pred(input logic [7:0] sr);
        return ~(sr[7] ^ sr[5] ^ sr[4] ^ sr[3]);
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [2:0]       fill_cnt_q, fill_cnt_d;
    logic [7:0]       good_cnt_q, good_cnt_d;
    logic [7:0]       bad_cnt_q, bad_cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             bit_err_q, bit_err_d;
    logic             locked_q, locked_d;
    logic [7:0]       sr_next_s;
    logic             miss_s;
    logic             err_hit_s;

    // Next-state, counter and error-accounting logic
    always_comb begin
        sr_next_s  = {sr_q[6:0], bit_in};
        // An all-ones window is the XNOR lockup state, so it is an error even when the bit matches
        miss_s     = (bit_in != lfsr_pred(sr_q)) || (sr_next_s == 8'hFF);
        sr_d       = sr_q;
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_hit_s  = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (bit_valid) begin
                    sr_d = sr_next_s;
                    if (fill_cnt_q == 3'd7) begin
                        state_d    = ST_SYNC;
                        fill_cnt_d = 3'd0;
                        good_cnt_d = 8'd0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 3'd1;
                    end
                end else begin
                    sr_d = sr_q;
                end
            end
            ST_SYNC: begin
                if (bit_valid) begin
                    sr_d = sr_next_s;
                    if (miss_s) begin
                        good_cnt_d = 8'd0;
                    end else if (good_cnt_q + 8'd1 == LOCK_C) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = 8'd0;
                        bad_cnt_d  = 8'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 8'd1;
                    end
                end else begin
                    sr_d = sr_q;
                end
            end
            ST_LOCKED: begin
                if (bit_valid) begin
                    sr_d = sr_next_s;
                    if (miss_s) begin
                        err_hit_s = 1'b1;
                        if (bad_cnt_q + 8'd1 == LOSS_C) begin
                            state_d   = ST_LOST;
                            bad_cnt_d = 8'd0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 8'd1;
                        end
                    end else begin
                        bad_cnt_d = 8'd0;
                    end
                end else begin
                    sr_d = sr_q;
                end
            end
            ST_LOST: begin
                // The strobe in this cycle, if any, is dropped; sr is kept for the refill
                state_d    = ST_FILL;
                fill_cnt_d = 3'd0;
            end
            default: begin
                state_d    = ST_FILL;
                fill_cnt_d = 3'd0;
            end
        endcase

        if (clear_err) begin
            err_count_d = {ERR_W{1'b0}};
        end else if (err_hit_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
        end else begin
            err_count_d = err_count_q;
        end
        bit_err_d = err_hit_s;
        locked_d  = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk50mhz or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FILL;
            sr_q        <= 8'h00;
            fill_cnt_q  <= 3'd0;
            good_cnt_q  <= 8'd0;
            bad_cnt_q   <= 8'd0;
            err_count_q <= {ERR_W{1'b0}};
            bit_err_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_cnt_q  <= fill_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_count_q <= err_count_d;
            bit_err_q   <= bit_err_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign state     = state_q;
    assign bit_err   = bit_err_q;
    assign err_count = err_count_q;
    assign seq_word  = sr_q;

`ifdef LFSR_CHK_HEX_EN
    DEC_7SEG u_hex0 (.hex_digit(err_count_q[3:0]), .segments(HEX0));
    DEC_7SEG u_hex1 (.hex_digit(err_count_q[7:4]), .segments(HEX1));
`else
    assign HEX0 = 7'b1111111;
    assign HEX1 = 7'b1111111;
`endif

endmodule
